// File: rtl/div_pkg.sv
// Shared constants, state encoding and the leading-digit helper for the BCD converter.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned BCD_NDIG  = 10;
    localparam int unsigned BCD_W     = 40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Position of the most significant nonzero BCD digit plus one; zero reports one digit.
    function automatic logic [3:0] lead_ndig(input logic [BCD_W-1:0] v);
        logic [3:0] n;
        n = 4'd1;
        for (int unsigned i = 0; i < BCD_NDIG; i++) begin
            if (v[i*4 +: 4] != 4'd0) begin
                n = 4'(i + 1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3_vec.sv
// Double-dabble correction: adds 3 to every BCD nibble that is 5 or more.
module bcd_add3_vec #(
    parameter int unsigned NDIG = 10
) (
    input  logic [NDIG*4-1:0] i_bcd,
    output logic [NDIG*4-1:0] o_bcd
);

    // One independent corrector per nibble.
    for (genvar g = 0; g < NDIG; g++) begin : g_nib
        assign o_bcd[g*4 +: 4] = (i_bcd[g*4 +: 4] >= 4'd5) ? (i_bcd[g*4 +: 4] + 4'd3)
                                                           : i_bcd[g*4 +: 4];
    end

endmodule

// File: rtl/div_bcd_conv.sv
// Converts one divider quotient/remainder pair to packed BCD by sequential shift-add-3,
// reporting significant-digit counts and the divide-by-zero flag alongside.
module div_bcd_conv
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned NDIG  = BCD_NDIG,
    parameter int unsigned CNTW  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  quotient,
    input  logic [WIDTH-1:0]  remainder,
    input  logic              div0,
    output logic [NDIG*4-1:0] q_bcd,
    output logic [NDIG*4-1:0] r_bcd,
    output logic [3:0]        q_ndig,
    output logic [3:0]        r_ndig,
    output logic              err,
    output logic              out_valid
);

    localparam int unsigned BW = NDIG * 4;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNTW-1:0] r_cnt;
    logic [WIDTH-1:0] r_q_bin;
    logic [WIDTH-1:0] r_r_bin;
    logic [BW-1:0]   r_q_acc;
    logic [BW-1:0]   r_r_acc;
    logic [BW-1:0]   w_q_adj;
    logic [BW-1:0]   w_r_adj;
    logic            r_div0;
    logic            w_accept;
    logic            w_last;

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_last   = (r_cnt == CNTW'(WIDTH - 1));

    bcd_add3_vec #(.NDIG(NDIG)) u_q_add3 (
        .i_bcd (r_q_acc),
        .o_bcd (w_q_adj)
    );

    bcd_add3_vec #(.NDIG(NDIG)) u_r_add3 (
        .i_bcd (r_r_acc),
        .o_bcd (w_r_adj)
    );

    // State register; in_ready is registered from the next state so it mirrors IDLE exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            in_ready <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            in_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last)   w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture and shift datapath: {bcd,bin} shifts left after the add-3 correction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_q_bin <= '0;
            r_r_bin <= '0;
            r_q_acc <= '0;
            r_r_acc <= '0;
            r_div0  <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_q_bin <= quotient;
            r_r_bin <= remainder;
            r_q_acc <= '0;
            r_r_acc <= '0;
            r_div0  <= div0;
        end else if (r_state == ST_SHIFT) begin
            r_q_acc <= {w_q_adj[BW-2:0], r_q_bin[WIDTH-1]};
            r_r_acc <= {w_r_adj[BW-2:0], r_r_bin[WIDTH-1]};
            r_q_bin <= {r_q_bin[WIDTH-2:0], 1'b0};
            r_r_bin <= {r_r_bin[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt + CNTW'(1);
        end
    end

    // Result registers, updated only when leaving DONE; held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_bcd     <= '0;
            r_bcd     <= '0;
            q_ndig    <= 4'd0;
            r_ndig    <= 4'd0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                q_bcd  <= r_q_acc;
                r_bcd  <= r_r_acc;
                q_ndig <= lead_ndig(r_q_acc);
                r_ndig <= lead_ndig(r_r_acc);
                err    <= r_div0;
            end
        end
    end

endmodule

// File: tb/tb_div_bcd_conv.sv
// Bench for div_bcd_conv: directed pairs with literal expectations plus a per-cycle model check.
module tb_div_bcd_conv;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div0;
    logic [39:0] q_bcd;
    logic [39:0] r_bcd;
    logic [3:0]  q_ndig;
    logic [3:0]  r_ndig;
    logic        err;
    logic        out_valid;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    div_bcd_conv dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div0      (div0),
        .q_bcd     (q_bcd),
        .r_bcd     (r_bcd),
        .q_ndig    (q_ndig),
        .r_ndig    (r_ndig),
        .err       (err),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Decimal digits by repeated division, most natural statement of "packed BCD".
    function automatic logic [39:0] to_bcd(input logic [31:0] v);
        logic [39:0] r;
        longint      x;
        r = '0;
        x = longint'(v);
        for (int i = 0; i < 10; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] dec_digits(input logic [31:0] v);
        longint x;
        int     n;
        x = longint'(v);
        n = 1;
        while (x >= 10) begin
            x = x / 10;
            n++;
        end
        return 4'(n);
    endfunction

    // Cycle-level reference: busy counts remaining non-IDLE cycles after a capture.
    int          busy = 0;
    logic        e_ov = 0;
    logic [39:0] e_q = '0, e_r = '0, p_q = '0, p_r = '0;
    logic [3:0]  e_qn = '0, e_rn = '0, p_qn = '0, p_rn = '0;
    logic        e_err = 0, p_err = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  64'(in_ready),  64'(busy == 0));
            chk("out_valid", 64'(out_valid), 64'(e_ov));
            chk("q_bcd",     64'(q_bcd),     64'(e_q));
            chk("r_bcd",     64'(r_bcd),     64'(e_r));
            chk("q_ndig",    64'(q_ndig),    64'(e_qn));
            chk("r_ndig",    64'(r_ndig),    64'(e_rn));
            chk("err",       64'(err),       64'(e_err));
        end
        if (reset) begin
            busy = 0; e_ov = 0;
            e_q = '0; e_r = '0; e_qn = '0; e_rn = '0; e_err = 0;
        end else begin
            e_ov = 0;
            if (busy == 0) begin
                if (in_valid) begin
                    busy  = 33;
                    p_q   = to_bcd(quotient);
                    p_r   = to_bcd(remainder);
                    p_qn  = dec_digits(quotient);
                    p_rn  = dec_digits(remainder);
                    p_err = div0;
                end
            end else begin
                busy--;
                if (busy == 0) begin
                    e_ov = 1;
                    e_q = p_q; e_r = p_r; e_qn = p_qn; e_rn = p_rn; e_err = p_err;
                end
            end
        end
    end

    // Waits (bounded) for out_valid and checks latency and literal result values.
    task automatic wait_check(input string nm, input logic [39:0] eq, input logic [39:0] er,
                              input logic [3:0] eqn, input logic [3:0] ern, input logic ee);
        int n;
        bit got;
        n = 0;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            n++;
            if (out_valid === 1'b1) got = 1;
        end
        chk({nm, "_latency"}, 64'(n),     64'(34));
        chk({nm, "_q_bcd"},   64'(q_bcd), 64'(eq));
        chk({nm, "_r_bcd"},   64'(r_bcd), 64'(er));
        chk({nm, "_q_ndig"},  64'(q_ndig), 64'(eqn));
        chk({nm, "_r_ndig"},  64'(r_ndig), 64'(ern));
        chk({nm, "_err"},     64'(err),   64'(ee));
    endtask

    task automatic send(input logic [31:0] q, input logic [31:0] r, input logic d);
        @(posedge clk); #1;
        quotient = q; remainder = r; div0 = d; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; quotient = '0; remainder = '0; div0 = 1'b0;

        // Pin the reference model to hand-derived values.
        chk("model_max",  64'(to_bcd(32'hFFFF_FFFF)), 64'(40'h4294967295));
        chk("model_ndig", 64'(dec_digits(32'hFFFF_FFFF)), 64'(10));

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1;
        @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_q_bcd",     64'(q_bcd),     64'(0));
        chk("rst_q_ndig",    64'(q_ndig),    64'(0));

        send(32'd13, 32'd1, 1'b0);
        wait_check("basic", 40'h13, 40'h1, 4'd2, 4'd1, 1'b0);

        send(32'hFFFF_FFFF, 32'd0, 1'b0);
        wait_check("max", 40'h4294967295, 40'h0, 4'd10, 4'd1, 1'b0);

        send(32'd0, 32'd13, 1'b1);
        wait_check("div0", 40'h0, 40'h13, 4'd1, 4'd2, 1'b1);

        send(32'd7, 32'd3, 1'b0);
        wait_check("div0_clr", 40'h7, 40'h3, 4'd1, 4'd1, 1'b0);

        // Inputs change and in_valid stays high while the first pair converts.
        @(posedge clk); #1;
        quotient = 32'd115; remainder = 32'd0; div0 = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        quotient = 32'd153;
        wait_check("busy1", 40'h115, 40'h0, 4'd3, 4'd1, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_check("busy2", 40'h153, 40'h0, 4'd3, 4'd1, 1'b0);

        // Abort a conversion with reset partway through.
        send(32'd1234567, 32'd89, 1'b0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_in_ready",  64'(in_ready),  64'(1));
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_q_bcd",     64'(q_bcd),     64'(0));
        chk("abort_r_bcd",     64'(r_bcd),     64'(0));
        repeat (40) @(negedge clk);

        send(32'd1234567, 32'd89, 1'b0);
        wait_check("fresh", 40'h1234567, 40'h89, 4'd7, 4'd2, 1'b0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_bcd_conv.md
Name: div_bcd_conv

Overview:
- Downstream stage of the 32-bit unsigned divider.
- Captures one quotient/remainder pair and converts both to packed BCD, 10 digits each, using sequential shift-add-3 (double dabble).
- Also reports the significant-digit count of each result, for the display/readout logic that follows.
- Quotient and remainder are converted in parallel over 32 shift cycles, behind a valid/ready handshake.

Parameters:
- WIDTH, 32, binary operand width; fixed at 32 for this revision.
- NDIG, 10, BCD digits per result; equals ceil(WIDTH*log10(2)).
- CNTW, 6, width of the shift counter; must hold the value WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  divider result valid.
- in_ready  out  1  block can accept a pair; high only in IDLE.
- quotient  in  32  unsigned quotient from the divider.
- remainder  in  32  unsigned remainder from the divider.
- div0  in  1  divider flagged a zero divisor for this pair.
- q_bcd  out  40  packed BCD quotient; digit 0 is bits [3:0].
- r_bcd  out  40  packed BCD remainder.
- q_ndig  out  4  significant digits in q_bcd, range 1..10.
- r_ndig  out  4  significant digits in r_bcd, range 1..10.
- err  out  1  registered copy of div0 for the presented pair.
- out_valid  out  1  one-cycle pulse; result outputs valid.

Behaviour:
- Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Values while reset is high, and after release:
  - state=IDLE, counter=0, all internal shift registers 0.
  - q_bcd=0, r_bcd=0, q_ndig=0, r_ndig=0, err=0, out_valid=0.
  - in_ready=1 from the first cycle after reset is released.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load quotient/remainder into binary shift registers, clear both 40-bit BCD accumulators, latch div0, counter=0, go to SHIFT.
  - With in_valid=0: stay in IDLE.
- SHIFT:
  - in_ready=0; in_valid and the data inputs are ignored.
  - Each edge, per accumulator: every nibble >=5 gets +3 (combinational), then {bcd,bin} shifts left by 1; counter increments.
  - When counter reaches WIDTH-1 on an edge, that edge performs the 32nd shift and moves the state to DONE.
- DONE, lasts exactly one cycle:
  - Register q_bcd, r_bcd, q_ndig, r_ndig and err from the accumulators.
  - out_valid=1 for this cycle only; next state IDLE.
  - in_ready=0 in DONE; a new pair is accepted no earlier than the following IDLE cycle.
- Latency and throughput:
  - Capture on edge E; out_valid is high in the cycle after edge E+33.
  - Sustained throughput is one pair per 34 cycles.
- Output hold: q_bcd/r_bcd/ndig/err keep their last values until the next DONE or a reset. Consumers sample them at out_valid.
- ndig rule: index of the most significant nonzero nibble, plus 1. A value of 0 gives ndig=1.
- Digit range: no nibble ever exceeds 9. 0xFFFFFFFF yields 40'h4294967295 with ndig=10; this is the overflow-free maximum.
- div0: passed through to err only. Conversion proceeds on whatever quotient/remainder the divider presented; no special-casing.
- Reset in SHIFT or DONE: aborts the conversion and returns to IDLE with all reset values. out_valid is never asserted for the aborted pair.
- in_valid held high across several transfers: one pair is captured per IDLE visit. The upstream side must not assume a hold-until-ready protocol beyond the rule "capture when in_valid && in_ready".

Decomposition:
- Package div_pkg holds:
  - constants DIV_WIDTH=32, BCD_NDIG=10, BCD_W=40;
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
- Sub-module bcd_add3_vec:
  - combinational, NDIG nibbles in and NDIG nibbles out, adds 3 to each nibble >=5;
  - instantiated twice, once for the quotient path and once for the remainder path.
- The leading-digit count is a small function in div_pkg, shared by both paths.

Test Plan:
- Reset: hold reset 3 cycles, then release -> all outputs 0, in_ready=1, out_valid never pulsed.
- Basic pair: quotient=13, remainder=1 (183/14), in_valid 1 cycle -> 34th cycle has out_valid=1; q_bcd=40'h13, q_ndig=2, r_bcd=40'h1, r_ndig=1, err=0.
- Zero and maximum: quotient=32'hFFFFFFFF, remainder=0 -> q_bcd=40'h4294967295, q_ndig=10, r_bcd=0, r_ndig=1.
- Div-by-zero flag: quotient=0, remainder=13, div0=1 -> err=1, q_bcd=0, r_bcd=40'h13. Next pair with div0=0 -> err returns to 0.
- Busy backpressure: capture 115/0, then change inputs to 153/0 with in_valid=1 during SHIFT -> first result 40'h115, in_ready=0 throughout SHIFT and DONE. Second pair is captured on the first IDLE edge and yields 40'h153 34 cycles later.
- Mid-conversion reset: assert reset 10 cycles after capture -> next cycle is IDLE with outputs 0 and no out_valid. A fresh pair then converts correctly.
